// File: rtl/poly1305_block_formatter.sv
// rtl/poly1305_block_formatter.sv - formats AAD/payload beats into padded Poly1305 blocks plus the length block
module poly1305_block_formatter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         aad_valid,
  output logic         aad_ready,
  input  logic [127:0] aad_data,
  input  logic [15:0]  aad_keep,
  input  logic         aad_last,
  input  logic         pld_valid,
  output logic         pld_ready,
  input  logic [127:0] pld_data,
  input  logic [15:0]  pld_keep,
  input  logic         pld_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [129:0] blk_data,
  output logic [1:0]   blk_kind,
  output logic         blk_last,
  output logic [63:0]  aad_len,
  output logic [63:0]  pld_len,
  output logic         busy,
  output logic         done,
  output logic         fmt_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_AAD, ST_PLD, ST_LEN} state_t;

  state_t       state, state_nx;
  logic [127:0] beat_data;
  logic [15:0]  beat_keep;
  logic         beat_last;
  logic         beat_fire;
  logic [127:0] masked;
  logic [4:0]   beat_bytes;
  logic         keep_bad;
  logic         out_free;
  logic         blk_fire;
  logic         load_beat;
  logic         load_len;

  // The single output register is free when empty or being drained this cycle
  assign out_free  = !blk_valid || blk_ready;
  assign aad_ready = (state == ST_AAD) && out_free;
  assign pld_ready = (state == ST_PLD) && out_free;
  assign blk_fire  = blk_valid && blk_ready;
  assign busy      = (state != ST_IDLE);

  // An empty beat only advances the stream; the length block waits until its slot is free
  assign load_beat = beat_fire && (|beat_keep);
  assign load_len  = (state == ST_LEN) && !blk_last && out_free;

  // Pick the active stream's beat, zero the unkept bytes, count bytes and check the keep shape
  always_comb begin
    if (state == ST_PLD) begin
      beat_data = pld_data;
      beat_keep = pld_keep;
      beat_last = pld_last;
      beat_fire = pld_valid && pld_ready;
    end else begin
      beat_data = aad_data;
      beat_keep = aad_keep;
      beat_last = aad_last;
      beat_fire = aad_valid && aad_ready;
    end
    masked     = '0;
    beat_bytes = '0;
    for (int i = 0; i < 16; i++) begin
      if (beat_keep[i]) begin
        masked[8*i +: 8] = beat_data[8*i +: 8];
        beat_bytes       = beat_bytes + 5'd1;
      end
    end
    // keep must be 2^n-1 (no holes), and only a last beat may be short
    keep_bad = (|(beat_keep & (beat_keep + 16'd1))) ||
               (!beat_last && (beat_keep != 16'hFFFF));
  end

  // Message phase sequencing
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_AAD;
      ST_AAD:  if (beat_fire && beat_last) state_nx = ST_PLD;
      ST_PLD:  if (beat_fire && beat_last) state_nx = ST_LEN;
      ST_LEN:  if (blk_fire && blk_last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Output block register: reload on accepted beat or length slot, hold under backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_kind  <= 2'd0;
      blk_last  <= 1'b0;
    end else if (load_beat) begin
      blk_valid <= 1'b1;
      blk_data  <= {2'b01, masked};
      blk_kind  <= (state == ST_PLD) ? 2'd1 : 2'd0;
      blk_last  <= 1'b0;
    end else if (load_len) begin
      blk_valid <= 1'b1;
      blk_data  <= {2'b01, pld_len, aad_len};
      blk_kind  <= 2'd2;
      blk_last  <= 1'b1;
    end else if (blk_fire) begin
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
    end
  end

  // Byte counters, sticky format error and the completion pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aad_len <= '0;
      pld_len <= '0;
      fmt_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == ST_LEN) && blk_fire && blk_last;
      if ((state == ST_IDLE) && start) begin
        aad_len <= '0;
        pld_len <= '0;
        fmt_err <= 1'b0;
      end else if (beat_fire) begin
        if (state == ST_PLD) pld_len <= pld_len + {59'd0, beat_bytes};
        else                 aad_len <= aad_len + {59'd0, beat_bytes};
        if (keep_bad) fmt_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_poly1305_block_formatter.sv
// tb/tb_poly1305_block_formatter.sv - randomized self-checking bench for poly1305_block_formatter
module tb_poly1305_block_formatter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         aad_valid, aad_ready, aad_last;
  logic [127:0] aad_data;
  logic [15:0]  aad_keep;
  logic         pld_valid, pld_ready, pld_last;
  logic [127:0] pld_data;
  logic [15:0]  pld_keep;
  logic         blk_valid, blk_ready, blk_last;
  logic [129:0] blk_data;
  logic [1:0]   blk_kind;
  logic [63:0]  aad_len, pld_len;
  logic         busy, done, fmt_err;

  poly1305_block_formatter dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_data(aad_data),
    .aad_keep(aad_keep), .aad_last(aad_last),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .pld_keep(pld_keep), .pld_last(pld_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_kind(blk_kind), .blk_last(blk_last),
    .aad_len(aad_len), .pld_len(pld_len),
    .busy(busy), .done(done), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state for the current message
  logic [127:0] a_data[$], p_data[$];
  logic [15:0]  a_keep[$], p_keep[$];
  bit           a_last[$], p_last[$];
  logic [129:0] exp_blk[$];
  logic [1:0]   exp_kind[$];
  logic [63:0]  exp_a, exp_p;
  bit           exp_err;

  task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ctl"}, {blk_valid, blk_last, busy, done, fmt_err, aad_ready, pld_ready, blk_kind}, 0);
    check({tag, "_data"}, blk_data, 0);
    check({tag, "_alen"}, aad_len, 0);
    check({tag, "_plen"}, pld_len, 0);
  endtask

  // Split a byte stream into beats and derive the blocks the formatter must produce from it
  task automatic build_stream(input bit is_pld, input int nbytes, input bit use_fk, input logic [15:0] fk);
    int           left;
    int           cnt;
    bit           last;
    logic [15:0]  k;
    logic [127:0] d, blk;
    left = nbytes;
    do begin
      if (use_fk) begin
        k    = fk;
        last = 1'b1;
      end else begin
        cnt  = (left > 16) ? 16 : left;
        k    = 16'((32'd1 << cnt) - 32'd1);
        last = (left <= 16);
        left -= cnt;
      end
      for (int w = 0; w < 4; w++) d[32*w +: 32] = $urandom();
      blk = '0;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (k[i]) begin
          blk[8*i +: 8] = d[8*i +: 8];
          cnt++;
        end
      end
      if ((k != 16'((32'd1 << cnt) - 32'd1)) || (!last && cnt != 16)) exp_err = 1'b1;
      if (is_pld) begin
        p_data.push_back(d); p_keep.push_back(k); p_last.push_back(last);
        exp_p += 64'(cnt);
      end else begin
        a_data.push_back(d); a_keep.push_back(k); a_last.push_back(last);
        exp_a += 64'(cnt);
      end
      if (cnt > 0) begin
        exp_blk.push_back({2'b01, blk});
        exp_kind.push_back(is_pld ? 2'd1 : 2'd0);
      end
    end while (!last);
  endtask

  // Run one message: random valid/ready, scoreboard every accepted block
  task automatic run_msg(input int na, input int np, input bit use_fk, input logic [15:0] fk,
                         input bit stall, input bit start_mid, input int abort_pi);
    int           cyc, ai, pi, stall_cnt, len_cyc;
    bit           seen_done, mid_sent, aborted;
    logic [129:0] held, e;
    logic [1:0]   k;
    a_data.delete(); a_keep.delete(); a_last.delete();
    p_data.delete(); p_keep.delete(); p_last.delete();
    exp_blk.delete(); exp_kind.delete();
    exp_a = 0; exp_p = 0; exp_err = 0;
    build_stream(1'b0, na, use_fk, fk);
    build_stream(1'b1, np, 1'b0, 16'h0);
    exp_blk.push_back({2'b01, exp_p, exp_a});
    exp_kind.push_back(2'd2);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_err_clr", fmt_err, 0);
    check("start_busy", busy, 1);
    check("start_alen", aad_len, 0);

    cyc = 0; ai = 0; pi = 0; stall_cnt = 0; len_cyc = -10;
    seen_done = 0; mid_sent = 0; aborted = 0;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (start_mid && !mid_sent && ai == a_data.size() && pi < p_data.size()) begin
        start    = 1'b1;
        mid_sent = 1;
      end
      if (ai < a_data.size()) begin
        aad_valid = ($urandom_range(0, 3) != 0);
        aad_data  = a_data[ai]; aad_keep = a_keep[ai]; aad_last = a_last[ai];
      end else aad_valid = 1'b0;
      if (pi < p_data.size()) begin
        pld_valid = ($urandom_range(0, 3) != 0);
        pld_data  = p_data[pi]; pld_keep = p_keep[pi]; pld_last = p_last[pi];
      end else pld_valid = 1'b0;
      if (stall && stall_cnt < 5) blk_ready = 1'b0;
      else                        blk_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stall && stall_cnt < 5 && blk_valid) begin
        if (stall_cnt == 0) held = blk_data;
        else check("stall_hold", blk_data, held);
        check("stall_aad_ready", aad_ready, 0);
        stall_cnt++;
      end
      if (aad_valid && aad_ready) ai++;
      if (pld_valid && pld_ready) pi++;
      if (blk_valid && blk_ready) begin
        if (exp_blk.size() == 0) check("extra_blk", 1, 0);
        else begin
          e = exp_blk.pop_front();
          k = exp_kind.pop_front();
          check("blk_data", blk_data, e);
          check("blk_kind", blk_kind, k);
          check("blk_last", blk_last, (k == 2'd2));
          if (k == 2'd2) len_cyc = cyc;
        end
      end
      if (done) begin
        seen_done = 1;
        check("done_latency", cyc - len_cyc, 1);
        check("done_busy", busy, 0);
      end
      if (abort_pi > 0 && pi >= abort_pi) begin
        aborted = 1;
        break;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check("done_seen", seen_done, 1);
      check("blks_left", exp_blk.size(), 0);
      check("aad_len", aad_len, exp_a);
      check("pld_len", pld_len, exp_p);
      check("fmt_err", fmt_err, exp_err);
      aad_valid = 1'b0; pld_valid = 1'b0;
      @(negedge clk);
      #1;
      check("done_pulse", done, 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; blk_ready = 1'b0;
    aad_valid = 1'b0; aad_data = '0; aad_keep = '0; aad_last = 1'b0;
    pld_valid = 1'b0; pld_data = '0; pld_keep = '0; pld_last = 1'b0;
    #1;
    reset_checks("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_msg(12, 19, 1'b0, 16'h0, 1'b0, 1'b0, 0);
    run_msg(0, 32, 1'b0, 16'h0, 1'b0, 1'b0, 0);
    run_msg(12, 5, 1'b0, 16'h0, 1'b1, 1'b0, 0);
    run_msg(0, 20, 1'b1, 16'h00F3, 1'b0, 1'b0, 0);
    check("err_bytes", aad_len, 6);
    run_msg(16, 40, 1'b0, 16'h0, 1'b0, 1'b1, 0);
    run_msg(0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 0);

    run_msg(16, 160, 1'b0, 16'h0, 1'b0, 1'b0, 2);
    reset_n = 1'b0;
    #1;
    reset_checks("midrst");
    aad_valid = 1'b0; pld_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_idle", blk_valid, 0);
    end
    run_msg(7, 33, 1'b0, 16'h0, 1'b0, 1'b0, 0);

    for (int m = 0; m < 25; m++)
      run_msg($urandom_range(0, 50), $urandom_range(0, 70), 1'b0, 16'h0,
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/poly1305_block_formatter.md
# poly1305_block_formatter

Upstream stage of the ChaCha20-Poly1305 Poly1305 datapath. It accepts the AAD stream and then the ciphertext/payload stream as 128-bit beats with byte keeps. It zero-pads each partial final beat to 16 bytes and appends the Poly1305 2^128 marker bit. After both streams it generates the RFC 8439 length block, and emits one 130-bit block per handshake to the Poly1305 accumulate/multiply stage.

## Interface
- No parameters.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a new message; honoured only in IDLE.
- aad_valid / aad_ready  in / out  1 / 1  AAD beat handshake.
- aad_data  in  128  AAD bytes; byte i at [8i+7:8i] (little-endian).
- aad_keep  in  16  byte enables; contiguous from bit 0.
- aad_last  in  1  final AAD beat.
- pld_valid / pld_ready  in / out  1 / 1  payload beat handshake.
- pld_data, pld_keep, pld_last  in  128, 16, 1  as for AAD.
- blk_valid / blk_ready  out / in  1 / 1  block output handshake.
- blk_data  out  130  Poly1305 block: [127:0] padded bytes, [128]=1, [129]=0.
- blk_kind  out  2  0=AAD, 1=payload, 2=length block.
- blk_last  out  1  set only on the length block.
- aad_len  out  64  AAD byte count of the current message.
- pld_len  out  64  payload byte count of the current message.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the length block is accepted.
- fmt_err  out  1  sticky keep-format error; cleared by an accepted start.

## Operation
- States:
  - IDLE → AAD on start.
  - AAD → PLD on an accepted beat with aad_last.
  - PLD → LEN on an accepted beat with pld_last.
  - LEN → IDLE when the length block is accepted (done pulses).
- start in IDLE clears aad_len, pld_len and fmt_err. start in any other state is ignored.
- Beat acceptance:
  - AAD beat: aad_valid && aad_ready. aad_ready = (state==AAD) && (!blk_valid || blk_ready).
  - Payload beat: same rule using pld_valid/pld_ready in PLD.
- Output register (single stage, no skid):
  - Loaded on each accepted beat.
  - Holds all of blk_* stable while blk_valid && !blk_ready.
  - Clears blk_valid on an accepted block with no new load in the same cycle.
- Padding:
  - Bytes with keep=0 are forced to zero in blk_data[127:0].
  - blk_data[128]=1 on every data block, including partial ones (AEAD zero-padding rule).
- Empty beat: a beat with keep=16'h0000 must have last=1. It advances state and emits no block. This is how zero-length AAD/payload is sent.
- Counting: an accepted beat adds popcount(keep) to aad_len or pld_len. Counters wrap modulo 2^64.
- Length block:
  - Entering LEN, the next free output cycle loads blk_data = {1'b0, 1'b1, pld_len, aad_len}, i.e. aad_len in [63:0] and pld_len in [127:64].
  - blk_kind=2, blk_last=1.
- fmt_err is set, and the beat is still processed, when either:
  - keep is not of the form 2^n-1, or
  - keep != 16'hFFFF on a beat with last=0.

## Timing
- Reset values:
  - State IDLE.
  - blk_valid, blk_last, busy, done, fmt_err, aad_ready, pld_ready = 0.
  - blk_data, blk_kind, aad_len, pld_len = 0.
- Latency: beat accepted in cycle N → blk_valid in cycle N+1.
- Throughput: one block per cycle while blk_ready stays high.
- Length block: blk_valid in the cycle after the last payload block is accepted, or after the PLD→LEN transition if the final beat was empty.
- Backpressure: blk_ready low stalls the input; aad_ready/pld_ready drop the same cycle (combinational on blk_valid/blk_ready).
- Simultaneous accept-out and accept-in in one cycle: the register reloads with no bubble.
- reset_n asserted mid-message: immediate return to reset values. No partial block is emitted afterwards.
- done is high only in the cycle following the length-block handshake. busy falls in that same cycle.

## Test plan
- AAD 12 bytes (keep 16'h0FFF, last), payload 16+3 bytes (keep FFFF, then 0007 last), blk_ready=1. Required blocks:
  - AAD block with bytes 12-15 zero, bit128=1.
  - Full payload block.
  - Payload block with bytes 3-15 zero.
  - Length block [127:0] = {64'd19, 64'd12}, blk_last=1.
  - done one cycle later; aad_len=12, pld_len=19.
- Zero-length AAD (keep 0, last) and 32-byte payload → exactly 2 payload blocks, then length block {64'd32, 64'd0}.
- blk_ready held low 5 cycles with a block pending → blk_data stable, aad_ready=0 throughout, no beat lost.
- aad_keep=16'h00F3 on a last beat → fmt_err=1, counts +6 bytes. A following start clears fmt_err.
- reset_n pulsed mid-payload → all outputs at reset values; a new message then completes correctly.
- start pulsed during PLD → ignored, counts unchanged.
